class_hv_accumulator: RTL and testbench

Sequential counter bank and controller for one class hypervector in the class-training datapath. It accepts a stream of binary hypervector chunks and presents the stored per-bit counter chunk to the combinational `adder_block`, then writes the returned sum back into the bank. On command it binarizes the bank by majority vote and streams the class hypervector out chunk by chunk. It sits directly around `adder_block`: upstream, it feeds `stored_hv_chunk` and `input_hv_chunk`; downstream, it consumes `sum`.

---
 rtl/class_hv_accumulator.sv | 170 +++++++++++++++++
 tb/tb_class_hv_accumulator.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/class_hv_accumulator.sv
// ============================================================================
// Module : class_hv_accumulator
// Brief  : Per-bit counter bank for one class hypervector. It accumulates
//          binary chunks through an external adder and reads out the
//          majority-vote result.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module class_hv_accumulator #(
  parameter int CHUNK_W    = 5,
  parameter int CNT_W      = 8,
  parameter int NUM_CHUNKS = 8,
  parameter int SCNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic                        bin_start_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [CHUNK_W-1:0]          in_chunk_i,
  input  logic                        in_last_i,
  output logic [CHUNK_W-1:0]          adder_in_chunk_o,
  output logic [CHUNK_W*CNT_W-1:0]    stored_chunk_o,
  input  logic [CHUNK_W*CNT_W-1:0]    sum_in_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [CHUNK_W-1:0]          out_chunk_o,
  output logic                        out_last_o,
  output logic                        busy_o,
  output logic [SCNT_W-1:0]           sample_cnt_o,
  output logic                        seq_err_o
);

  localparam int PTR_W  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int WORD_W = CHUNK_W * CNT_W;
  localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_BIN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [SCNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic                seq_err_q, seq_err_d;
  logic [WORD_W-1:0]   bank_q [NUM_CHUNKS];

  logic                w_bank_we;
  logic [PTR_W-1:0]    w_bank_waddr;
  logic [WORD_W-1:0]   w_bank_wdata;
  logic                w_ptr_last;
  logic [PTR_W-1:0]    w_ptr_inc;

  assign w_ptr_last = (ptr_q == c_LAST_PTR);
  assign w_ptr_inc  = w_ptr_last ? '0 : ptr_q + PTR_W'(1);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sample_cnt_d = sample_cnt_q;
    seq_err_d    = seq_err_q;
    w_bank_we    = 1'b0;
    w_bank_waddr = ptr_q;
    w_bank_wdata = sum_in_i;
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    out_last_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready_o = !clear_i && !bin_start_i;
        if (clear_i) begin
          state_d      = ST_CLR;
          ptr_d        = '0;
          sample_cnt_d = '0;
          seq_err_d    = 1'b0;
        end else if (bin_start_i) begin
          if (ptr_q == '0) begin
            state_d = ST_BIN;
          end else begin
            seq_err_d = 1'b1;
          end
        end else if (in_valid_i) begin
          w_bank_we = 1'b1;
          if (in_last_i && w_ptr_last) begin
            ptr_d = '0;
            if (sample_cnt_q != '1) begin
              sample_cnt_d = sample_cnt_q + SCNT_W'(1);
            end
          end else if (in_last_i || w_ptr_last) begin
            // Misframed hypervector: resynchronise to chunk 0.
            seq_err_d = 1'b1;
            ptr_d     = '0;
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
      end

      ST_CLR: begin
        w_bank_we    = 1'b1;
        w_bank_wdata = '0;
        ptr_d        = w_ptr_inc;
        if (w_ptr_last) begin
          state_d = ST_IDLE;
        end
      end

      ST_BIN: begin
        out_valid_o = 1'b1;
        out_last_o  = w_ptr_last;
        if (out_ready_i) begin
          ptr_d = w_ptr_inc;
          if (w_ptr_last) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      sample_cnt_q <= '0;
      seq_err_q    <= 1'b0;
      for (int k = 0; k < NUM_CHUNKS; k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sample_cnt_q <= sample_cnt_d;
      seq_err_q    <= seq_err_d;
      if (w_bank_we) begin
        bank_q[w_bank_waddr] <= w_bank_wdata;
      end
    end
  end

  // Majority vote: 2*cnt > samples, widened so the doubling never overflows.
  generate
    for (genvar gi = 0; gi < CHUNK_W; gi++) begin : g_bin
      logic [SCNT_W:0] w_cnt_ext;
      logic [SCNT_W:0] w_cnt_dbl;
      assign w_cnt_ext = (SCNT_W+1)'(bank_q[ptr_q][gi*CNT_W +: CNT_W]);
      assign w_cnt_dbl = {w_cnt_ext[SCNT_W-1:0], 1'b0};
      assign out_chunk_o[gi] = (state_q == ST_BIN) &&
                               (w_cnt_dbl > {1'b0, sample_cnt_q});
    end
  endgenerate

  assign adder_in_chunk_o = in_chunk_i;
  assign stored_chunk_o   = bank_q[ptr_q];
  assign busy_o           = (state_q != ST_IDLE);
  assign sample_cnt_o     = sample_cnt_q;
  assign seq_err_o        = seq_err_q;

endmodule

`default_nettype wire

// File: tb/tb_class_hv_accumulator.sv
// ============================================================================
// Module : tb_class_hv_accumulator
// Brief  : Self-checking bench for class_hv_accumulator with a behavioural
//          counter-bank reference model and an adder model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_class_hv_accumulator;

  localparam int CHUNK_W    = 5;
  localparam int CNT_W      = 8;
  localparam int NUM_CHUNKS = 8;
  localparam int SCNT_W     = 16;
  localparam int WORD_W     = CHUNK_W * CNT_W;

  logic                clk;
  logic                rst;
  logic                clear;
  logic                bin_start;
  logic                in_valid;
  logic                in_ready;
  logic [CHUNK_W-1:0]  in_chunk;
  logic                in_last;
  logic [CHUNK_W-1:0]  adder_in_chunk;
  logic [WORD_W-1:0]   stored_chunk;
  logic [WORD_W-1:0]   sum_in;
  logic                out_valid;
  logic                out_ready;
  logic [CHUNK_W-1:0]  out_chunk;
  logic                out_last;
  logic                busy;
  logic [SCNT_W-1:0]   sample_cnt;
  logic                seq_err;

  class_hv_accumulator #(
    .CHUNK_W    (CHUNK_W),
    .CNT_W      (CNT_W),
    .NUM_CHUNKS (NUM_CHUNKS),
    .SCNT_W     (SCNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .clear_i          (clear),
    .bin_start_i      (bin_start),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_chunk_i       (in_chunk),
    .in_last_i        (in_last),
    .adder_in_chunk_o (adder_in_chunk),
    .stored_chunk_o   (stored_chunk),
    .sum_in_i         (sum_in),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_chunk_o      (out_chunk),
    .out_last_o       (out_last),
    .busy_o           (busy),
    .sample_cnt_o     (sample_cnt),
    .seq_err_o        (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder_block: per-bit counter plus input bit.
  always_comb begin
    sum_in = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      sum_in[i*CNT_W +: CNT_W] = stored_chunk[i*CNT_W +: CNT_W] + CNT_W'(adder_in_chunk[i]);
    end
  end

  int checks   = 0;
  int failures = 0;

  // Reference model of the bank contents and framing state.
  int mb [NUM_CHUNKS][CHUNK_W];
  int mptr;
  int mcnt;
  bit merr;

  typedef struct {
    logic [CHUNK_W-1:0] chunk;
    logic               last;
    logic               exp_err;
    logic [SCNT_W-1:0]  exp_cnt;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NUM_CHUNKS; p++)
      for (int i = 0; i < CHUNK_W; i++)
        mb[p][i] = 0;
    mptr = 0;
    mcnt = 0;
    merr = 1'b0;
  endtask

  function automatic logic [WORD_W-1:0] mword(input int p);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < CHUNK_W; i++) w[i*CNT_W +: CNT_W] = CNT_W'(mb[p][i]);
    return w;
  endfunction

  function automatic logic [CHUNK_W-1:0] exp_bin(input int p);
    logic [CHUNK_W-1:0] b;
    for (int i = 0; i < CHUNK_W; i++) b[i] = (2 * mb[p][i] > mcnt);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic [CHUNK_W-1:0] ch, input logic lst);
    in_valid = 1'b1;
    in_chunk = ch;
    in_last  = lst;
    #1;
    chk("in_ready", 64'(in_ready), 64'd1);
    chk("stored_chunk", 64'(stored_chunk), 64'(mword(mptr)));
    chk("adder_in_chunk", 64'(adder_in_chunk), 64'(ch));
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < CHUNK_W; i++) mb[mptr][i] += int'(ch[i]);
    if (lst && mptr == NUM_CHUNKS - 1) begin
      if (mcnt < 65535) mcnt++;
      mptr = 0;
    end else if (lst || mptr == NUM_CHUNKS - 1) begin
      merr = 1'b1;
      mptr = 0;
    end else begin
      mptr++;
    end
    chk("sample_cnt", 64'(sample_cnt), 64'(mcnt));
    chk("seq_err", 64'(seq_err), 64'(merr));
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic bin_readout(input int mode);
    int h;
    int cyc;
    bit hs;
    bit prev_stalled;
    logic [CHUNK_W-1:0] prev_chunk;
    bin_start = 1'b1;
    #1;
    chk("in_ready_on_bin_start", 64'(in_ready), 64'd0);
    tick();
    bin_start    = 1'b0;
    h            = 0;
    cyc          = 0;
    prev_stalled = 1'b0;
    prev_chunk   = '0;
    while (h < NUM_CHUNKS && cyc < 64) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      chk("bin_out_valid", 64'(out_valid), 64'd1);
      chk("bin_busy", 64'(busy), 64'd1);
      chk("bin_out_chunk", 64'(out_chunk), 64'(exp_bin(h)));
      chk("bin_out_last", 64'(out_last), 64'(h == NUM_CHUNKS - 1));
      chk("bin_stored_chunk", 64'(stored_chunk), 64'(mword(h)));
      if (prev_stalled) chk("bin_out_chunk_stable", 64'(out_chunk), 64'(prev_chunk));
      prev_chunk   = out_chunk;
      prev_stalled = !out_ready;
      hs           = out_ready;
      tick();
      if (hs) h++;
      cyc++;
    end
    chk("bin_handshakes", 64'(h), 64'(NUM_CHUNKS));
    out_ready = 1'b0;
    #1;
    chk("post_bin_busy", 64'(busy), 64'd0);
    chk("post_bin_out_valid", 64'(out_valid), 64'd0);
    chk("post_bin_out_chunk", 64'(out_chunk), 64'd0);
    chk("post_bin_in_ready", 64'(in_ready), 64'd1);
    chk("post_bin_stored_ptr0", 64'(stored_chunk), 64'(mword(0)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    bin_start = 1'b0;
    in_valid  = 1'b0;
    in_chunk  = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_chunk", 64'(out_chunk), 64'd0);
    chk("rst_sample_cnt", 64'(sample_cnt), 64'd0);
    chk("rst_seq_err", 64'(seq_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stored", 64'(stored_chunk), 64'd0);

    // Three all-ones hypervectors, then two of 5'b10101.
    for (int hv = 0; hv < 3; hv++)
      for (int c = 0; c < NUM_CHUNKS; c++) drive_in(5'b11111, c == NUM_CHUNKS - 1);
    chk("bank_after_3hv", 64'(stored_chunk), 64'({5{8'd3}}));
    for (int hv = 0; hv < 2; hv++)
      for (int c = 0; c < NUM_CHUNKS; c++) drive_in(5'b10101, c == NUM_CHUNKS - 1);
    chk("bank_after_5hv", 64'(stored_chunk), 64'({8'd5, 8'd3, 8'd5, 8'd3, 8'd5}));
    chk("sample_cnt_5", 64'(sample_cnt), 64'd5);

    bin_readout(0);
    bin_readout(1);

    // Framing vectors: early last on the 3rd chunk, then resync at bank[0].
    vecs[0] = '{chunk: 5'h01, last: 1'b0, exp_err: 1'b0, exp_cnt: 16'd5};
    vecs[1] = '{chunk: 5'h02, last: 1'b0, exp_err: 1'b0, exp_cnt: 16'd5};
    vecs[2] = '{chunk: 5'h04, last: 1'b1, exp_err: 1'b1, exp_cnt: 16'd5};
    vecs[3] = '{chunk: 5'h08, last: 1'b0, exp_err: 1'b1, exp_cnt: 16'd5};
    vecs[4] = '{chunk: 5'h10, last: 1'b0, exp_err: 1'b1, exp_cnt: 16'd5};
    for (int k = 0; k < 5; k++) begin
      drive_in(vecs[k].chunk, vecs[k].last);
      chk("vec_seq_err", 64'(seq_err), 64'(vecs[k].exp_err));
      chk("vec_sample_cnt", 64'(sample_cnt), 64'(vecs[k].exp_cnt));
    end

    // clear and bin_start together: clear wins.
    clear     = 1'b1;
    bin_start = 1'b1;
    in_valid  = 1'b1;
    #1;
    chk("clr_in_ready_cmd", 64'(in_ready), 64'd0);
    tick();
    clear     = 1'b0;
    bin_start = 1'b0;
    in_valid  = 1'b0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      #1;
      chk("clr_busy", 64'(busy), 64'd1);
      chk("clr_out_valid", 64'(out_valid), 64'd0);
      chk("clr_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    model_reset();
    chk("clr_done_busy", 64'(busy), 64'd0);
    chk("clr_done_in_ready", 64'(in_ready), 64'd1);
    chk("clr_sample_cnt", 64'(sample_cnt), 64'd0);
    chk("clr_seq_err", 64'(seq_err), 64'd0);
    bin_readout(2);

    // bin_start with ptr != 0 is ignored and flags an error.
    drive_in(5'h03, 1'b0);
    drive_in(5'h05, 1'b0);
    bin_start = 1'b1;
    tick();
    bin_start = 1'b0;
    merr = 1'b1;
    #1;
    chk("bin_ignored_busy", 64'(busy), 64'd0);
    chk("bin_ignored_out_valid", 64'(out_valid), 64'd0);
    chk("bin_ignored_seq_err", 64'(seq_err), 64'd1);
    chk("bin_ignored_stored", 64'(stored_chunk), 64'(mword(2)));
    for (int c = 2; c < NUM_CHUNKS; c++) drive_in(5'h1E, c == NUM_CHUNKS - 1);

    // Randomised accumulation with occasional misframing and idle cycles.
    for (int n = 0; n < 160; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_stored", 64'(stored_chunk), 64'(mword(mptr)));
        tick();
      end else begin
        drive_in(CHUNK_W'($urandom_range(0, 31)),
                 (mptr == NUM_CHUNKS - 1) ^ ($urandom_range(0, 9) == 0));
      end
    end
    while (mptr != 0) drive_in(CHUNK_W'($urandom_range(0, 31)), mptr == NUM_CHUNKS - 1);
    bin_readout(2);

    // Reset on the 4th BIN cycle.
    bin_start = 1'b1;
    tick();
    bin_start = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("bin4_out_valid", 64'(out_valid), 64'd1);
    chk("bin4_out_chunk", 64'(out_chunk), 64'(exp_bin(3)));
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #1;
    chk("midbin_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midbin_rst_busy", 64'(busy), 64'd0);
    chk("midbin_rst_out_last", 64'(out_last), 64'd0);
    chk("midbin_rst_sample_cnt", 64'(sample_cnt), 64'd0);
    chk("midbin_rst_seq_err", 64'(seq_err), 64'd0);
    for (int c = 0; c < NUM_CHUNKS; c++) drive_in(5'b00000, c == NUM_CHUNKS - 1);
    chk("midbin_rst_cnt_after", 64'(sample_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
